// File: rtl/updown_counter_param.sv
// Parametrised up/down event/timebase counter with a terminal value, an enable prescaler,
// parallel load, synchronous clear, wrap or saturate at the limits, and status flags.
module updown_counter_param #(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
    parameter int          SATURATE = 0,
    parameter int          PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sync_clr,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_max,
    output logic             at_zero
);

    localparam int               PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] C_MAX      = MAX_VAL[WIDTH-1:0];
    localparam logic [PW-1:0]    C_PS_LAST  = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] C_CNT_ONE  = WIDTH'(1);
    localparam logic [PW-1:0]    C_PS_ONE   = PW'(1);

    logic [WIDTH-1:0] r_count;
    logic [PW-1:0]    r_ps;
    logic             r_wrap;

    logic             w_step;
    logic [PW-1:0]    w_ps_next;
    logic [WIDTH-1:0] w_count_step;
    logic             w_wrap_step;
    logic [WIDTH-1:0] w_load_clamped;

    // The step value is computed every cycle; it only matters on edges where w_step fires.
    always_comb begin
        w_step       = enable && (r_ps == C_PS_LAST);
        w_ps_next    = w_step ? '0 : (r_ps + C_PS_ONE);
        w_count_step = r_count;
        w_wrap_step  = 1'b0;
        if (up_dn) begin
            if (r_count == C_MAX) begin
                if (SATURATE == 0) begin
                    w_count_step = '0;
                    w_wrap_step  = 1'b1;
                end
            end else begin
                w_count_step = r_count + C_CNT_ONE;
            end
        end else begin
            if (r_count == '0) begin
                if (SATURATE == 0) begin
                    w_count_step = C_MAX;
                    w_wrap_step  = 1'b1;
                end
            end else begin
                w_count_step = r_count - C_CNT_ONE;
            end
        end
    end

    assign w_load_clamped = (load_val > C_MAX) ? C_MAX : load_val;

    // Priority: clear, then load, then enabled prescale/step; wrap defaults low every edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_ps    <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (sync_clr) begin
                r_count <= '0;
                r_ps    <= '0;
            end else if (load) begin
                r_count <= w_load_clamped;
                r_ps    <= '0;
            end else if (enable) begin
                r_ps <= w_ps_next;
                if (w_step) begin
                    r_count <= w_count_step;
                    r_wrap  <= w_wrap_step;
                end
            end
        end
    end

    assign count   = r_count;
    assign wrap    = r_wrap;
    assign at_max  = (r_count == C_MAX);
    assign at_zero = (r_count == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: wrap, saturate and prescaled variants
// driven from shared inputs, checked against hand-computed values.
module tb_updown_counter_param;

    logic       clk;
    logic       reset_n;
    logic       sync_clr;
    logic       enable;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] a_count, s_count, p_count;
    logic       a_wrap, s_wrap, p_wrap;
    logic       a_at_max, s_at_max, p_at_max;
    logic       a_at_zero, s_at_zero, p_at_zero;

    int n_checks = 0;
    int n_bad    = 0;

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)) u_a (
        .clk(clk), .reset_n(reset_n), .sync_clr(sync_clr), .enable(enable),
        .up_dn(up_dn), .load(load), .load_val(load_val),
        .count(a_count), .wrap(a_wrap), .at_max(a_at_max), .at_zero(a_at_zero)
    );

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1)) u_s (
        .clk(clk), .reset_n(reset_n), .sync_clr(sync_clr), .enable(enable),
        .up_dn(up_dn), .load(load), .load_val(load_val),
        .count(s_count), .wrap(s_wrap), .at_max(s_at_max), .at_zero(s_at_zero)
    );

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(3)) u_p (
        .clk(clk), .reset_n(reset_n), .sync_clr(sync_clr), .enable(enable),
        .up_dn(up_dn), .load(load), .load_val(load_val),
        .count(p_count), .wrap(p_wrap), .at_max(p_at_max), .at_zero(p_at_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_v;
        reset_n  = 1'b0;
        sync_clr = 1'b0;
        enable   = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = 4'd0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(a_count), 0);
        check("rst_wrap", 32'(a_wrap), 0);
        check("rst_at_zero", 32'(a_at_zero), 1);
        check("rst_at_max", 32'(a_at_max), 0);
        reset_n = 1'b1;

        // count up across MAX_VAL=9 with wrap
        enable = 1'b1;
        up_dn  = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_v = i % 10;
            check("up_count", 32'(a_count), 32'(exp_v));
            check("up_wrap", 32'(a_wrap), (i == 10) ? 1 : 0);
            check("up_at_max", 32'(a_at_max), (exp_v == 9) ? 1 : 0);
            check("up_at_zero", 32'(a_at_zero), (exp_v == 0) ? 1 : 0);
        end

        // load then count down through zero
        enable   = 1'b0;
        load     = 1'b1;
        load_val = 4'd3;
        step();
        check("load3", 32'(a_count), 3);
        load   = 1'b0;
        enable = 1'b1;
        up_dn  = 1'b0;
        begin
            int dn_exp[5] = '{2, 1, 0, 9, 8};
            for (int i = 0; i < 5; i++) begin
                step();
                check("dn_count", 32'(a_count), 32'(dn_exp[i]));
                check("dn_wrap", 32'(a_wrap), (dn_exp[i] == 9) ? 1 : 0);
            end
        end
        enable   = 1'b0;
        load     = 1'b1;
        load_val = 4'd15;
        step();
        check("load_clamp", 32'(a_count), 9);
        check("load_clamp_max", 32'(a_at_max), 1);
        check("load_no_wrap", 32'(a_wrap), 0);

        // saturating instance
        load_val = 4'd8;
        step();
        check("sat_load8", 32'(s_count), 8);
        load   = 1'b0;
        enable = 1'b1;
        up_dn  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("sat_up", 32'(s_count), 9);
            check("sat_up_wrap", 32'(s_wrap), 0);
        end
        enable   = 1'b0;
        load     = 1'b1;
        load_val = 4'd1;
        step();
        check("sat_load1", 32'(s_count), 1);
        load   = 1'b0;
        enable = 1'b1;
        up_dn  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("sat_dn", 32'(s_count), 0);
            check("sat_dn_wrap", 32'(s_wrap), 0);
        end

        // prescaler = 3
        enable   = 1'b0;
        sync_clr = 1'b1;
        step();
        check("ps_clr", 32'(p_count), 0);
        sync_clr = 1'b0;
        enable   = 1'b1;
        up_dn    = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            check("ps_count", 32'(p_count), 32'(k / 3));
        end
        step();
        check("ps_e10", 32'(p_count), 3);
        enable = 1'b0;
        step();
        check("ps_hold1", 32'(p_count), 3);
        step();
        check("ps_hold2", 32'(p_count), 3);
        enable = 1'b1;
        step();
        check("ps_e13", 32'(p_count), 3);
        step();
        check("ps_e14", 32'(p_count), 4);

        // priority: clear beats load beats step
        sync_clr = 1'b1;
        load     = 1'b1;
        load_val = 4'd5;
        enable   = 1'b1;
        step();
        check("prio_clr", 32'(a_count), 0);
        sync_clr = 1'b0;
        step();
        check("prio_load", 32'(a_count), 5);
        load   = 1'b0;
        enable = 1'b0;
        step();
        check("prio_hold", 32'(a_count), 5);

        // async reset between edges
        load     = 1'b1;
        load_val = 4'd7;
        step();
        check("pre_rst7", 32'(a_count), 7);
        load = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_rst", 32'(a_count), 0);
        check("async_rst_zero", 32'(a_at_zero), 1);
        #1;
        reset_n = 1'b1;
        enable  = 1'b1;
        up_dn   = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("post_rst_a", 32'(a_count), 32'(i));
            check("post_rst_p", 32'(p_count), (i == 3) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
